rv32_dmem_responder: RTL

Data-memory responder for the pipelined RV32 core: the target side of the core's MEM-stage load/store request interface. It accepts one request at a time and models a configurable access latency. It performs byte/half/word stores with byte enables and returns sign- or zero-extended load data. It flags misaligned, reserved-size and out-of-range accesses. It sits beside rv32_pipelined in the top-level and testbench, and replaces an ideal zero-latency data array.

---
 rtl/rv32_mem_pkg.sv | 37 +++
 rtl/rv32_dmem_responder_if.sv | 23 ++
 rtl/rv32_dmem_array.sv | 30 +++
 rtl/rv32_dmem_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared encodings and helpers for the RV32 data-memory responder.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_RSV = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam int unsigned MAX_LATENCY = 15;

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   res = uns ? {24'b0, b} : {{24{b[7]}}, b};
      MEM_H:   res = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32_dmem_responder_if.sv
// MEM-stage load/store request/response bus between the core and the data memory.
interface rv32_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32_dmem_array.sv
// Single-port word array with byte-enable writes and a registered read port.
module rv32_dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read register only updates on loads, so it holds the last load result.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Latency-modelling data-memory target for the pipelined RV32 core's MEM stage.
module rv32_dmem_responder
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  rv32_dmem_responder_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e   state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] widx_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          err_q;

  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          rsp_load_q;
  logic [1:0]    rsp_lane_q;
  logic [1:0]    rsp_size_q;
  logic          rsp_uns_q;

  logic [31:0]   req_off;
  logic          req_err;
  logic [AW-1:0] req_widx;
  logic          is_idle;
  logic          commit;

  logic          cur_we;
  logic [AW-1:0] cur_widx;
  logic [1:0]    cur_lane;
  logic [31:0]   cur_wdata;
  logic [1:0]    cur_size;
  logic          cur_uns;
  logic          cur_err;

  logic [3:0]    arr_be;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  // Out-of-range check wraps, so addresses below BASE_ADDR land far above SPAN.
  assign req_off  = bus.req_addr - BASE_ADDR;
  assign req_widx = bus.req_addr[AW+1:2] - BASE_ADDR[AW+1:2];

  always_comb begin
    req_err = ({1'b0, req_off} >= SPAN);
    case (bus.req_size)
      MEM_B:   ;
      MEM_H:   if (bus.req_addr[0]) req_err = 1'b1;
      MEM_W:   if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  assign is_idle = (state_q == IDLE);

  // With LATENCY=1 the commit edge is the acceptance edge, so use the live bus.
  assign cur_we    = is_idle ? bus.req_we           : we_q;
  assign cur_widx  = is_idle ? req_widx             : widx_q;
  assign cur_lane  = is_idle ? bus.req_addr[1:0]    : lane_q;
  assign cur_wdata = is_idle ? bus.req_wdata        : wdata_q;
  assign cur_size  = is_idle ? bus.req_size         : size_q;
  assign cur_uns   = is_idle ? bus.req_unsigned     : uns_q;
  assign cur_err   = is_idle ? req_err              : err_q;

  assign commit = (is_idle && bus.req_valid && (LATENCY == 1)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

  always_comb begin
    arr_be    = 4'b0000;
    arr_wdata = cur_wdata;
    case (cur_size)
      MEM_B: begin
        arr_be    = 4'b0001 << cur_lane;
        arr_wdata = {4{cur_wdata[7:0]}};
      end
      MEM_H: begin
        arr_be    = cur_lane[1] ? 4'b1100 : 4'b0011;
        arr_wdata = {2{cur_wdata[15:0]}};
      end
      MEM_W:   arr_be = 4'b1111;
      default: arr_be = 4'b0000;
    endcase
  end

  rv32_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (commit && !cur_err),
    .we    (cur_we),
    .be    (arr_be),
    .addr  (cur_widx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      widx_q      <= '0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_lane_q  <= 2'b00;
      rsp_size_q  <= 2'b00;
      rsp_uns_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err;
        rsp_load_q  <= !cur_we && !cur_err;
        rsp_lane_q  <= cur_lane;
        rsp_size_q  <= cur_size;
        rsp_uns_q   <= cur_uns;
      end
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            widx_q  <= req_widx;
            lane_q  <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            err_q   <= req_err;
            cnt_q   <= LAT_M1;
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = is_idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_load_q ? load_extract(arr_rdata, rsp_lane_q, rsp_size_q, rsp_uns_q)
                                    : 32'h0;

endmodule
